image_frame_buffer: RTL and testbench

//  Double-buffered (ping-pong) frame store for input images ahead of the NN datapath.

---
 rtl/image_frame_buffer.sv | 124 ++++++++++++
 tb/tb_image_frame_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_buffer.sv
// Ping-pong frame store. The writer fills one bank while the reader drains the other.
// Full banks pass from writer to reader through a full[] bit pair and a request/release handshake.
module image_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_abort,
    output logic              wr_ready,
    output logic              frame_written,
    output logic              wr_error,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_frame_avail,
    input  logic              rd_release,
    output logic [1:0]        frames_pending
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [2][DEPTH];

    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [ADDR_W-1:0] wr_count;
    logic [ADDR_W-1:0] prev_addr;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic              wr_drop;
    logic              wr_complete;
    logic              rd_release_ok;
    logic              rd_fire;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_ready       = !full[wr_bank];
    assign rd_frame_avail = full[rd_bank];

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;

    // Abort masks the write path entirely, so a colliding write neither lands nor flags an error.
    assign wr_accept   = wr_en && !wr_abort && wr_ready && wr_in_range && (wr_addr != prev_addr);
    assign wr_drop     = wr_en && !wr_abort && (!wr_ready || !wr_in_range);
    assign wr_complete = wr_accept && (wr_count == LAST_CNT);

    assign rd_release_ok = rd_release && rd_frame_avail;
    assign rd_fire       = rd_req && rd_frame_avail;

    // Out-of-range read addresses are folded onto entry 0; their data is don't-care.
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_in_range ? rd_addr[IDX_W-1:0] : '0;

    // Completion and release can never target the same bank: one needs it empty, the other full.
    always_comb begin
        full_nxt = full;
        if (wr_complete)   full_nxt[wr_bank] = 1'b1;
        if (rd_release_ok) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_accept)
            mem[wr_bank][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            wr_count  <= '0;
            prev_addr <= '1;
        end else if (wr_abort) begin
            wr_count  <= '0;
            prev_addr <= '1;
        end else if (wr_complete) begin
            wr_bank   <= !wr_bank;
            wr_count  <= '0;
            prev_addr <= '1;
        end else if (wr_accept) begin
            wr_count  <= wr_count + ADDR_W'(1);
            prev_addr <= wr_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full           <= 2'b00;
            rd_bank        <= 1'b0;
            frames_pending <= 2'd0;
            frame_written  <= 1'b0;
            wr_error       <= 1'b0;
        end else begin
            full           <= full_nxt;
            frames_pending <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
            frame_written  <= wr_complete;
            if (wr_drop)       wr_error <= 1'b1;
            if (rd_release_ok) rd_bank  <= !rd_bank;
        end
    end

    // Read uses the pre-toggle rd_bank, so a read paired with a release sees the outgoing frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire)
                rd_data <= mem[rd_bank][rd_idx];
        end
    end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Bench for image_frame_buffer: a DEPTH=784 instance for full-size frames and a DEPTH=4
// instance for bank handoff corners. Read data is checked through per-instance scoreboards.
module tb_image_frame_buffer;
    logic clk;
    logic reset;

    logic        a_wr_en, a_wr_abort, a_rd_req, a_rd_release;
    logic [15:0] a_wr_addr, a_rd_addr;
    logic [7:0]  a_wr_data, a_rd_data;
    logic        a_wr_ready, a_frame_written, a_wr_error, a_rd_valid, a_rd_frame_avail;
    logic [1:0]  a_frames_pending;

    logic        b_wr_en, b_wr_abort, b_rd_req, b_rd_release;
    logic [15:0] b_wr_addr, b_rd_addr;
    logic [7:0]  b_wr_data, b_rd_data;
    logic        b_wr_ready, b_frame_written, b_wr_error, b_rd_valid, b_rd_frame_avail;
    logic [1:0]  b_frames_pending;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    image_frame_buffer #(.DATA_W(8), .DEPTH(784), .ADDR_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_abort(a_wr_abort),
        .wr_ready(a_wr_ready), .frame_written(a_frame_written), .wr_error(a_wr_error),
        .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .rd_frame_avail(a_rd_frame_avail), .rd_release(a_rd_release),
        .frames_pending(a_frames_pending)
    );

    image_frame_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_abort(b_wr_abort),
        .wr_ready(b_wr_ready), .frame_written(b_frame_written), .wr_error(b_wr_error),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .rd_frame_avail(b_rd_frame_avail), .rd_release(b_rd_release),
        .frames_pending(b_frames_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read-data monitors: pop one expectation per rd_valid cycle.
    initial forever begin
        @(negedge clk);
        if (!reset && a_rd_valid) begin
            if (qa.size() == 0) chk("a_rd_unexpected", a_rd_valid, 0);
            else                chk("a_rd_data", a_rd_data, qa.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && b_rd_valid) begin
            if (qb.size() == 0) chk("b_rd_unexpected", b_rd_valid, 0);
            else                chk("b_rd_data", b_rd_data, qb.pop_front());
        end
    end

    task automatic a_wr(input int addr, input int data);
        a_wr_en = 1'b1; a_wr_addr = 16'(addr); a_wr_data = 8'(data);
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic b_wr(input int addr, input int data);
        b_wr_en = 1'b1; b_wr_addr = 16'(addr); b_wr_data = 8'(data);
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic a_rd(input int addr, input int exp);
        a_rd_req = 1'b1; a_rd_addr = 16'(addr);
        qa.push_back(8'(exp));
        tick();
        chk("a_rd_latency", a_rd_valid, 1);
        a_rd_req = 1'b0;
    endtask

    task automatic b_rd(input int addr, input int exp);
        b_rd_req = 1'b1; b_rd_addr = 16'(addr);
        qb.push_back(8'(exp));
        tick();
        chk("b_rd_latency", b_rd_valid, 1);
        b_rd_req = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        $display("reset check: %s", tag);
        chk("a_rst_wr_ready", a_wr_ready, 1);
        chk("a_rst_fw", a_frame_written, 0);
        chk("a_rst_err", a_wr_error, 0);
        chk("a_rst_rd_valid", a_rd_valid, 0);
        chk("a_rst_rd_data", a_rd_data, 0);
        chk("a_rst_avail", a_rd_frame_avail, 0);
        chk("a_rst_pending", a_frames_pending, 0);
        chk("b_rst_wr_ready", b_wr_ready, 1);
        chk("b_rst_fw", b_frame_written, 0);
        chk("b_rst_err", b_wr_error, 0);
        chk("b_rst_rd_valid", b_rd_valid, 0);
        chk("b_rst_rd_data", b_rd_data, 0);
        chk("b_rst_avail", b_rd_frame_avail, 0);
        chk("b_rst_pending", b_frames_pending, 0);
    endtask

    // One full 784-pixel frame with a 3-cycle hold on addr 5, readback, then release.
    task automatic a_frame();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 784; i++) begin
            int n;
            n = (i == 5) ? 3 : 1;
            repeat (n) begin
                a_wr(i, i);
                if (i != 783) pulses += int'(a_frame_written);
            end
        end
        chk("a_fw_on_last", a_frame_written, 1);
        chk("a_fw_early", pulses, 0);
        chk("a_avail", a_rd_frame_avail, 1);
        chk("a_wr_ready", a_wr_ready, 1);
        chk("a_pending", a_frames_pending, 1);
        chk("a_err", a_wr_error, 0);
        tick();
        chk("a_fw_width", a_frame_written, 0);
        a_rd(5, 5);
        a_rd(783, 783 % 256);
        a_rd(0, 0);
        a_rd_release = 1'b1;
        tick();
        a_rd_release = 1'b0;
        chk("a_pending_rel", a_frames_pending, 0);
    endtask

    initial begin
        reset = 1'b1;
        a_wr_en = 0; a_wr_abort = 0; a_rd_req = 0; a_rd_release = 0;
        a_wr_addr = 0; a_wr_data = 0; a_rd_addr = 0;
        b_wr_en = 0; b_wr_abort = 0; b_rd_req = 0; b_rd_release = 0;
        b_wr_addr = 0; b_wr_data = 0; b_rd_addr = 0;
        tick(); tick();
        chk_reset_vals("power-up");
        reset = 1'b0;
        tick();

        a_frame();

        // Read with no full bank.
        b_rd_req = 1'b1; b_rd_addr = 16'd0;
        tick();
        chk("b_rd_empty_valid", b_rd_valid, 0);
        chk("b_rd_empty_data", b_rd_data, 0);
        b_rd_req = 1'b0;

        // Frame A then frame B fills both banks.
        for (int i = 0; i < 4; i++) begin
            b_wr(i, 10 + i);
            chk("b_fw_A", b_frame_written, (i == 3) ? 1 : 0);
        end
        chk("b_pending_A", b_frames_pending, 1);
        chk("b_avail_A", b_rd_frame_avail, 1);
        chk("b_ready_A", b_wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            b_wr(i, 20 + i);
            chk("b_fw_B", b_frame_written, (i == 3) ? 1 : 0);
        end
        chk("b_ready_full", b_wr_ready, 0);
        chk("b_pending_full", b_frames_pending, 2);
        chk("b_err_before_drop", b_wr_error, 0);
        b_wr(0, 99);
        chk("b_err_drop", b_wr_error, 1);
        chk("b_pending_drop", b_frames_pending, 2);

        // Drain A; last read shares its cycle with release.
        b_rd(0, 10); b_rd(1, 11); b_rd(2, 12);
        b_rd_release = 1'b1;
        b_rd(3, 13);
        b_rd_release = 1'b0;
        chk("b_pending_relA", b_frames_pending, 1);
        chk("b_ready_relA", b_wr_ready, 1);
        for (int i = 0; i < 4; i++) b_rd(i, 20 + i);

        // Completion and release in the same cycle.
        b_wr(0, 30); b_wr(1, 31); b_wr(2, 32);
        b_rd_release = 1'b1;
        b_wr(3, 33);
        b_rd_release = 1'b0;
        chk("b_fw_coinc", b_frame_written, 1);
        chk("b_pending_coinc", b_frames_pending, 1);
        chk("b_avail_coinc", b_rd_frame_avail, 1);
        b_rd(3, 33); b_rd(0, 30);

        // Abort after two writes; the colliding write is ignored.
        b_wr(0, 40); b_wr(1, 41);
        b_wr_abort = 1'b1;
        b_wr(2, 77);
        b_wr_abort = 1'b0;
        chk("b_fw_abort", b_frame_written, 0);
        for (int i = 0; i < 4; i++) begin
            b_wr(i, 50 + i);
            chk("b_fw_fresh", b_frame_written, (i == 3) ? 1 : 0);
        end
        chk("b_pending_abort", b_frames_pending, 2);
        b_rd(1, 31);
        b_rd_release = 1'b1;
        tick();
        b_rd_release = 1'b0;
        b_rd(2, 52); b_rd(0, 50);

        // Reset mid-frame on A and mid-read on B.
        a_wr(0, 1); a_wr(1, 2);
        b_rd_req = 1'b1; b_rd_addr = 16'd1;
        tick();
        chk("b_rd_pre_reset", b_rd_valid, 1);
        b_rd_req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_reset_vals("async mid-cycle");
        tick();
        reset = 1'b0;
        tick();

        a_frame();
        for (int i = 0; i < 4; i++) begin
            b_wr(i, 60 + i);
            chk("b_fw_post_reset", b_frame_written, (i == 3) ? 1 : 0);
        end
        chk("b_pending_post_reset", b_frames_pending, 1);
        chk("b_err_post_reset", b_wr_error, 0);
        b_rd(2, 62);
        tick(); tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
